// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - EXU/WBU handshake and data-memory bus bundle for the load/store unit
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              exu_valid;
    logic              lsu_ready;
    logic              is_load;
    logic              is_store;
    logic [2:0]        mem_width;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    logic              lsu_valid;
    logic              wbu_ready;
    logic [DATA_W-1:0] rdata;
    logic              misaligned;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    // slave is the LSU itself; master is the surrounding EXU/WBU/memory
    modport slave (
        input  exu_valid, is_load, is_store, mem_width, addr, wdata,
        input  wbu_ready, mem_req_ready, mem_resp_valid, mem_resp_rdata,
        output lsu_ready, lsu_valid, rdata, misaligned,
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output exu_valid, is_load, is_store, mem_width, addr, wdata,
        output wbu_ready, mem_req_ready, mem_resp_valid, mem_resp_rdata,
        input  lsu_ready, lsu_valid, rdata, misaligned,
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one op in flight, single-outstanding memory bus, extended load result to WBU
module lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   rst,
    lsu_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t            state, state_nxt;
    logic              st_q;
    logic              ld_q;
    logic [2:0]        width_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              mis_q;

    logic              in_half, in_word, in_mis, in_mem;
    logic              q_byte, q_half;
    logic [DATA_W-1:0] lane;
    logic [DATA_W-1:0] load_val;
    logic              accept, resp_take;

    // 011/110/111 fall into the word case
    always_comb begin
        in_half = (bus.mem_width == 3'b001) || (bus.mem_width == 3'b101);
        in_word = (bus.mem_width[1:0] != 2'b00) && !in_half;
        in_mis  = (in_half && bus.addr[0]) || (in_word && (bus.addr[1:0] != 2'b00));
        in_mem  = bus.is_load || bus.is_store;
        q_byte  = (width_q == 3'b000) || (width_q == 3'b100);
        q_half  = (width_q == 3'b001) || (width_q == 3'b101);
    end

    assign accept    = (state == IDLE) && bus.exu_valid;
    assign resp_take = bus.mem_resp_valid &&
                       ((state == RESP) || ((state == REQ) && bus.mem_req_ready));
    assign lane      = bus.mem_resp_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_val = lane;
        case (width_q)
            3'b000:  load_val = {{(DATA_W-8){lane[7]}}, lane[7:0]};
            3'b100:  load_val = {{(DATA_W-8){1'b0}}, lane[7:0]};
            3'b001:  load_val = {{(DATA_W-16){lane[15]}}, lane[15:0]};
            3'b101:  load_val = {{(DATA_W-16){1'b0}}, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            st_q    <= 1'b0;
            ld_q    <= 1'b0;
            width_q <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                st_q    <= bus.is_store;
                ld_q    <= bus.is_load && !bus.is_store;
                width_q <= bus.mem_width;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                rdata_q <= '0;
                mis_q   <= in_mis && in_mem;
            end else if (resp_take && ld_q) begin
                rdata_q <= load_val;
            end else if ((state == DONE) && bus.wbu_ready) begin
                mis_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.lsu_ready     = 1'b0;
        bus.lsu_valid     = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_wen       = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.mem_wstrb     = 4'b0000;
        case (state)
            IDLE: begin
                bus.lsu_ready = 1'b1;
                if (bus.exu_valid)
                    state_nxt = (in_mem && !in_mis) ? REQ : DONE;
            end
            REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_wen       = st_q;
                bus.mem_addr      = {addr_q[ADDR_W-1:2], 2'b00};
                bus.mem_wdata     = wdata_q << {addr_q[1:0], 3'b000};
                if (st_q) begin
                    if (q_byte)      bus.mem_wstrb = 4'b0001 << addr_q[1:0];
                    else if (q_half) bus.mem_wstrb = 4'b0011 << addr_q[1:0];
                    else             bus.mem_wstrb = 4'b1111;
                end
                if (bus.mem_req_ready)
                    state_nxt = bus.mem_resp_valid ? DONE : RESP;
            end
            RESP: begin
                if (bus.mem_resp_valid)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.lsu_valid = 1'b1;
                if (bus.wbu_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.rdata      = rdata_q;
    assign bus.misaligned = mis_q;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized bench for lsu against a byte-lane reference model
module tb_lsu;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_lsu_ready"}, 32'(bus.lsu_ready), 32'd1);
        chk({pfx, "_lsu_valid"}, 32'(bus.lsu_valid), 32'd0);
        chk({pfx, "_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        chk({pfx, "_wen"}, 32'(bus.mem_wen), 32'd0);
        chk({pfx, "_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
        chk({pfx, "_maddr"}, bus.mem_addr, 32'd0);
        chk({pfx, "_mwdata"}, bus.mem_wdata, 32'd0);
        chk({pfx, "_rdata"}, bus.rdata, 32'd0);
        chk({pfx, "_mis"}, 32'(bus.misaligned), 32'd0);
    endtask

    function automatic int op_size(input logic [2:0] w);
        if (w == 3'd0 || w == 3'd4) return 1;
        if (w == 3'd1 || w == 3'd5) return 2;
        return 4;
    endfunction

    // expected extended load result computed lane by lane with plain arithmetic
    function automatic logic [31:0] model_load(input logic [2:0] w, input logic [31:0] a, input logic [31:0] word);
        int          sz;
        int          off;
        logic [31:0] v;
        sz  = op_size(w);
        off = int'(a[1:0]);
        v   = word / (32'd1 << (8 * off));
        if (sz == 4) return v;
        v = v % (32'd1 << (8 * sz));
        if (!w[2] && (v >= (32'd1 << (8 * sz - 1))))
            v = v - (32'd1 << (8 * sz));
        return v;
    endfunction

    task automatic run_op(input logic ld, input logic st, input logic [2:0] w,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rw,
                          input int req_dly, input int resp_dly, input int wbu_dly);
        int          sz, off, lat, reqcyc, respcnt, wcnt, e_lat;
        bit          mis, mem, acc, rgiven, vseen, done;
        logic [3:0]  e_strb;
        logic [31:0] e_rdata;

        sz  = op_size(w);
        off = int'(a[1:0]);
        mis = (ld || st) && ((sz == 2 && a[0]) || (sz == 4 && off != 0));
        mem = (ld || st) && !mis;
        e_strb = 4'b0000;
        if (st)
            for (int i = 0; i < 4; i++)
                if (i >= off && i < off + sz) e_strb[i] = 1'b1;
        e_rdata = (mem && ld && !st) ? model_load(w, a, rw) : 32'd0;
        e_lat   = mem ? 2 + req_dly + resp_dly : 1;

        // an idle-time response must be ignored
        bus.mem_resp_valid = 1'($urandom_range(0, 1));
        bus.mem_resp_rdata = $urandom;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        chk("pre_ready", 32'(bus.lsu_ready), 32'd1);

        bus.exu_valid = 1'b1;
        bus.is_load   = ld;
        bus.is_store  = st;
        bus.mem_width = w;
        bus.addr      = a;
        bus.wdata     = wd;
        @(negedge clk);
        bus.exu_valid = 1'b0;
        bus.is_load   = 1'($urandom_range(0, 1));
        bus.is_store  = 1'($urandom_range(0, 1));
        bus.mem_width = 3'($urandom_range(0, 7));
        bus.addr      = $urandom;
        bus.wdata     = $urandom;
        chk("post_accept_ready", 32'(bus.lsu_ready), 32'd0);

        lat = 1; reqcyc = 0; respcnt = 0; wcnt = 0;
        acc = 0; rgiven = 0; vseen = 0; done = 0;
        while (!done && lat < 300) begin
            bus.mem_req_ready  = 1'b0;
            bus.mem_resp_valid = 1'b0;
            bus.wbu_ready      = 1'b0;
            bus.mem_resp_rdata = $urandom;
            if (bus.mem_req_valid) begin
                chk("req_addr", bus.mem_addr, {a[31:2], 2'b00});
                chk("req_wen", 32'(bus.mem_wen), 32'(st));
                chk("req_wstrb", 32'(bus.mem_wstrb), 32'(e_strb));
                if (st) chk("req_wdata", bus.mem_wdata, wd << (8 * off));
                if (reqcyc == req_dly) begin
                    bus.mem_req_ready = 1'b1;
                    acc = 1;
                    if (resp_dly == 0) begin
                        bus.mem_resp_valid = 1'b1;
                        bus.mem_resp_rdata = rw;
                        rgiven = 1;
                    end
                end
                reqcyc++;
            end else if (acc && !rgiven) begin
                respcnt++;
                if (respcnt == resp_dly) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_resp_rdata = rw;
                    rgiven = 1;
                end
            end
            if (bus.lsu_valid) begin
                if (!vseen) chk("latency", 32'(lat), 32'(e_lat));
                vseen = 1;
                chk("rdata", bus.rdata, e_rdata);
                chk("misaligned", 32'(bus.misaligned), 32'(mis));
                if (wcnt == wbu_dly) begin
                    bus.wbu_ready = 1'b1;
                    done = 1;
                end
                wcnt++;
            end
            @(negedge clk);
            lat++;
        end
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.wbu_ready      = 1'b0;
        chk("completed", 32'(done), 32'd1);
        chk("req_cycles", 32'(reqcyc), mem ? 32'(req_dly + 1) : 32'd0);
        chk("idle_ready", 32'(bus.lsu_ready), 32'd1);
        chk("idle_valid", 32'(bus.lsu_valid), 32'd0);
        chk("idle_mis", 32'(bus.misaligned), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst                = 1'b0;
        bus.exu_valid      = 1'b0;
        bus.is_load        = 1'b0;
        bus.is_store       = 1'b0;
        bus.mem_width      = 3'd0;
        bus.addr           = '0;
        bus.wdata          = '0;
        bus.wbu_ready      = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        run_op(0, 0, 3'b010, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 0);
        run_op(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 0, 0, 0);
        run_op(1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FF7F, 0, 0, 0);
        run_op(0, 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 0, 0, 0);
        run_op(1, 0, 3'b001, 32'h8000_0006, 32'h0, 32'h8123_4567, 5, 3, 2);
        run_op(0, 1, 3'b010, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 5, 3, 2);
        run_op(1, 0, 3'b010, 32'h8000_0001, 32'h0, 32'h1111_1111, 0, 0, 0);
        run_op(1, 0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        run_op(1, 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 1, 1);
        run_op(1, 0, 3'b111, 32'h8000_0008, 32'h0, 32'h0BAD_F00D, 0, 2, 0);

        for (int n = 0; n < 150; n++) begin
            run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // reset while waiting for a load response
        bus.exu_valid = 1'b1;
        bus.is_load   = 1'b1;
        bus.is_store  = 1'b0;
        bus.mem_width = 3'b010;
        bus.addr      = 32'h8000_0010;
        @(negedge clk);
        bus.exu_valid = 1'b0;
        chk("rst_req_valid", 32'(bus.mem_req_valid), 32'd1);
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("rst_in_resp", 32'(bus.lsu_valid | bus.mem_req_valid | bus.lsu_ready), 32'd0);
        #2 rst = 1'b0;
        #1 chk_reset_outputs("midresp");
        @(negedge clk);
        rst = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = 32'h1234_5678;
        @(negedge clk);
        bus.mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("late_resp_valid", 32'(bus.lsu_valid), 32'd0);
            chk("late_resp_ready", 32'(bus.lsu_ready), 32'd1);
            @(negedge clk);
        end
        run_op(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'hF00F_0FF0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
